fast_path_scheduler: RTL and testbench
======================================

Name: fast_path_scheduler

Overview:
- Arbitrates `SUP_PATHS` parallel FAST beat streams into the single previous-value decoder datapath (overflow FIFO plus copy/increment/tail operators).
- Uses round-robin selection with field lock: once a path wins, it owns the decoder until its field-complete beat is accepted, so beats of different fields never interleave.
- Has a registered output stage, a per-field beat watchdog, and a grant tag so downstream logic can attribute each decoded field to its path.

Parameters:
- BEAT_WIDTH, 64, payload bits per beat.
- SUP_PATHS, 4, number of requesting paths (≥2).
- MAX_FIELD_BEATS, 4, maximum beats per field before forced abort; matches the 4-entry overflow FIFO.

Ports:
- clk  in  1  clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- in_valid  in  SUP_PATHS  per-path beat valid.
- in_beat  in  SUP_PATHS x BEAT_WIDTH  per-path beat payload.
- in_last  in  SUP_PATHS  per-path field-complete flag (stop bit seen in this beat).
- in_ready  out  SUP_PATHS  per-path accept.
- out_valid  out  1  beat to decoder valid.
- out_beat  out  BEAT_WIDTH  beat payload.
- out_last  out  1  field complete; drives the decoder FIFO read enable.
- out_abort  out  1  field truncated by the watchdog.
- out_path  out  clog2(SUP_PATHS)  source path of the beat.
- out_ready  in  1  decoder accept.
- err_valid  out  1  one-cycle watchdog error pulse.
- err_path  out  clog2(SUP_PATHS)  path that overran.
- busy  out  1  FSM in LOCKED state.

Behaviour:
- Reset (async, rstn=0):
  - out_valid, out_last, out_abort, err_valid, busy = 0.
  - out_beat, out_path, err_path = 0.
  - rr_ptr = 0, beat_cnt = 0, FSM = IDLE.
  - in_ready = 0 while rstn is low.
- Definitions:
  - Transfer on path p: in_valid[p] && in_ready[p].
  - `adv` = !out_valid || out_ready (output register may load).
- Ready rule: in_ready[p] = adv && (p == sel). At most one in_ready bit is high per cycle.
- Selection, combinational:
  - IDLE: sel = first p with in_valid[p] = 1, searching from rr_ptr upward with wrap-around. If none is valid, no in_ready is asserted.
  - LOCKED: sel = owner only. Other paths stall regardless of their valid.
- FSM IDLE:
  - Transfer with in_last=1: stay IDLE; rr_ptr ← (sel+1) mod SUP_PATHS.
  - Transfer with in_last=0: owner ← sel, beat_cnt ← 1, go to LOCKED.
- FSM LOCKED:
  - Transfer with in_last=1: go to IDLE; rr_ptr ← owner+1 (mod); beat_cnt ← 0.
  - Transfer with in_last=0 and beat_cnt+1 == MAX_FIELD_BEATS (watchdog):
    - Registered beat gets out_last=1 and out_abort=1.
    - err_valid=1 for exactly one cycle, err_path=owner.
    - Go to IDLE; rr_ptr ← owner+1.
    - The path's following beats are arbitrated as a new field.
  - Otherwise: beat_cnt ← beat_cnt+1.
- Output register:
  - On a transfer: out_valid ← 1, out_beat/out_last/out_path ← selected path values, out_abort as above.
  - Else if out_ready: out_valid ← 0.
  - Latency is 1 cycle from input transfer to out_valid.
  - Throughput is 1 beat/cycle with out_ready held high.
- Backpressure:
  - out_valid && !out_ready holds out_* stable and drives all in_ready to 0.
  - FSM, owner, rr_ptr and beat_cnt are frozen while stalled.
- Single-beat fields (in_last on the first beat) never enter LOCKED, so busy stays 0.
- MAX_FIELD_BEATS = 1: every beat is forced last; a beat with in_last=0 aborts, a beat with in_last=1 completes normally.
- Simultaneous events:
  - A watchdog abort and in_last=1 on the same beat is a normal completion: no abort, no err_valid.
  - An owner deasserting in_valid mid-field keeps the lock and does not advance beat_cnt.
- Reset mid-field: all state clears immediately. The partial field is dropped and no out_last is emitted for it.

Test Plan:
- Paths 0 and 2 valid with single-beat fields (in_last=1), out_ready=1 → out_path sequence 0,2,0,2; each out_valid 1 cycle after transfer; busy never 1.
- Path 1 sends a 3-beat field (last on beat 3) while path 3 stays valid → out_path 1,1,1 then 3; in_ready[3]=0 during LOCKED; out_last only on the 3rd path-1 beat.
- Path 0 sends 5 beats with no last, MAX_FIELD_BEATS=4 → 4th output beat has out_last=1 and out_abort=1; err_valid pulses once with err_path=0; 5th beat is accepted as a new field after other valid paths get their round-robin turn.
- out_ready=0 for 3 cycles mid-field → out_beat/out_path held stable; in_ready all 0; no beats lost or duplicated; beat_cnt unchanged.
- rstn pulsed low during beat 2 of a LOCKED field → outputs 0 asynchronously; after release rr_ptr=0, FSM=IDLE, and the first grant goes to the lowest valid path.
- All 4 paths continuously valid with single-beat fields → grants rotate 0,1,2,3,0; no path is starved beyond SUP_PATHS-1 grants.

Source files
------------

// File: rtl/fast_path_scheduler_if.sv
`default_nettype none
// ============================================================================
//  Module   : fast_path_scheduler_if
//  Purpose  : Bundles the multi-path FAST beat request side, the single
//             decoder-facing beat stream, the watchdog error pulse and the
//             busy flag of fast_path_scheduler.
//  Ports    : none (signal bundle only)
//             slave  modport - scheduler view (consumes path beats,
//                              produces the decoder stream)
//             master modport - environment view (drives path beats and
//                              decoder ready, observes the rest)
//  Revision : 1.0 - initial release
// ============================================================================
interface fast_path_scheduler_if #(
  parameter int BEAT_WIDTH = 64,
  parameter int SUP_PATHS  = 4
) ();
  localparam int PW = $clog2(SUP_PATHS);

  logic [SUP_PATHS-1:0]                 in_valid;
  logic [SUP_PATHS-1:0][BEAT_WIDTH-1:0] in_beat;
  logic [SUP_PATHS-1:0]                 in_last;
  logic [SUP_PATHS-1:0]                 in_ready;
  logic                                 out_valid;
  logic [BEAT_WIDTH-1:0]                out_beat;
  logic                                 out_last;
  logic                                 out_abort;
  logic [PW-1:0]                        out_path;
  logic                                 out_ready;
  logic                                 err_valid;
  logic [PW-1:0]                        err_path;
  logic                                 busy;

  modport slave (
    input  in_valid, in_beat, in_last, out_ready,
    output in_ready, out_valid, out_beat, out_last, out_abort, out_path,
           err_valid, err_path, busy
  );

  modport master (
    output in_valid, in_beat, in_last, out_ready,
    input  in_ready, out_valid, out_beat, out_last, out_abort, out_path,
           err_valid, err_path, busy
  );
endinterface
`default_nettype wire

// File: rtl/fast_path_scheduler.sv
`default_nettype none
// ============================================================================
//  Module   : fast_path_scheduler
//  Purpose  : Round-robin arbiter with field lock feeding SUP_PATHS FAST beat
//             streams into one previous-value decoder. A path that wins keeps
//             the decoder until its field-complete beat is taken; a watchdog
//             truncates fields longer than MAX_FIELD_BEATS.
//  Ports    : clk  - clock, rising edge
//             rstn - asynchronous active-low reset
//             bus  - fast_path_scheduler_if.slave (path beats in, decoder
//                    beats out with last/abort/path tag, error pulse, busy)
//  Revision : 1.0 - initial release
// ============================================================================
module fast_path_scheduler #(
  parameter int BEAT_WIDTH      = 64,
  parameter int SUP_PATHS       = 4,
  parameter int MAX_FIELD_BEATS = 4
) (
  input  wire logic              clk,
  input  wire logic              rstn,
  fast_path_scheduler_if.slave   bus
);
  localparam int PW = $clog2(SUP_PATHS);
  localparam int CW = $clog2(MAX_FIELD_BEATS + 1);

  localparam logic [0:0]    c_st_idle   = 1'b0;
  localparam logic [0:0]    c_st_locked = 1'b1;
  localparam logic [CW-1:0] c_cnt_one   = CW'(1);
  localparam logic [CW-1:0] c_cnt_max   = CW'(MAX_FIELD_BEATS);
  localparam logic [PW-1:0] c_path_one  = PW'(1);
  localparam logic [PW-1:0] c_path_last = PW'(SUP_PATHS - 1);
  localparam logic [PW:0]   c_paths     = (PW+1)'(SUP_PATHS);

  logic [0:0]            r_state, w_state_nxt;
  logic [PW-1:0]         r_rr_ptr, r_owner;
  logic [CW-1:0]         r_beat_cnt;
  logic                  r_out_valid, r_out_last, r_out_abort, r_err_valid;
  logic [BEAT_WIDTH-1:0] r_out_beat;
  logic [PW-1:0]         r_out_path, r_err_path;

  logic [PW-1:0]         w_sel, w_sel_inc, w_cand;
  logic [PW:0]           w_sum;
  logic                  w_found, w_grant, w_adv, w_xfer, w_last, w_wd, w_done;
  logic [SUP_PATHS-1:0]  w_ready;
  logic                  w_busy;

  // Selection: owner when locked, otherwise first valid path at or after rr_ptr.
  always_comb begin : p_select
    w_sel   = r_owner;
    w_found = 1'b0;
    w_sum   = '0;
    w_cand  = '0;
    if (r_state == c_st_locked) begin
      w_found = bus.in_valid[r_owner];
    end else begin
      for (int i = 0; i < SUP_PATHS; i++) begin
        w_sum = {1'b0, r_rr_ptr} + (PW+1)'(i);
        if (w_sum >= c_paths) w_sum = w_sum - c_paths;
        w_cand = w_sum[PW-1:0];
        if (!w_found && bus.in_valid[w_cand]) begin
          w_found = 1'b1;
          w_sel   = w_cand;
        end
      end
    end
  end

  assign w_adv     = !r_out_valid || bus.out_ready;
  // A locked owner is offered the slot even while it idles its valid.
  assign w_grant   = (r_state == c_st_locked) || w_found;
  assign w_xfer    = w_adv && w_found;
  assign w_last    = bus.in_last[w_sel];
  // beat_cnt is 0 in IDLE, so the same compare covers MAX_FIELD_BEATS == 1.
  assign w_wd      = !w_last && ((r_beat_cnt + c_cnt_one) == c_cnt_max);
  assign w_done    = w_last || w_wd;
  assign w_sel_inc = (w_sel == c_path_last) ? '0 : (w_sel + c_path_one);

  // FSM: state register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= c_st_idle;
    else       r_state <= w_state_nxt;
  end

  // FSM: next state
  always_comb begin : p_next
    w_state_nxt = r_state;
    if (w_xfer) begin
      if (w_done) w_state_nxt = c_st_idle;
      else        w_state_nxt = c_st_locked;
    end
  end

  // FSM: outputs
  always_comb begin : p_fsm_out
    w_busy  = (r_state == c_st_locked);
    w_ready = '0;
    if (rstn && w_adv && w_grant) w_ready[w_sel] = 1'b1;
  end

  // Arbitration bookkeeping and registered decoder stage.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_rr_ptr    <= '0;
      r_owner     <= '0;
      r_beat_cnt  <= '0;
      r_out_valid <= 1'b0;
      r_out_beat  <= '0;
      r_out_last  <= 1'b0;
      r_out_abort <= 1'b0;
      r_out_path  <= '0;
      r_err_valid <= 1'b0;
      r_err_path  <= '0;
    end else begin
      r_err_valid <= w_xfer && w_wd;
      if (w_xfer) begin
        if (w_done) begin
          r_rr_ptr   <= w_sel_inc;
          r_beat_cnt <= '0;
        end else begin
          r_owner    <= w_sel;
          r_beat_cnt <= r_beat_cnt + c_cnt_one;
        end
        if (w_wd) r_err_path <= w_sel;
        r_out_valid <= 1'b1;
        r_out_beat  <= bus.in_beat[w_sel];
        r_out_last  <= w_done;
        r_out_abort <= w_wd;
        r_out_path  <= w_sel;
      end else if (bus.out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = w_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_beat  = r_out_beat;
  assign bus.out_last  = r_out_last;
  assign bus.out_abort = r_out_abort;
  assign bus.out_path  = r_out_path;
  assign bus.err_valid = r_err_valid;
  assign bus.err_path  = r_err_path;
  assign bus.busy      = w_busy;
endmodule
`default_nettype wire

// File: tb/tb_fast_path_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
//  Module   : tb_fast_path_scheduler
//  Purpose  : Scoreboard bench for fast_path_scheduler. Per-path beat queues
//             feed the DUT; a cycle-level reference of the arbitration rules
//             predicts each accepted beat, and a negedge monitor compares
//             every beat the decoder takes against the prediction queue.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fast_path_scheduler;
  localparam int BW  = 64;
  localparam int NP  = 4;
  localparam int MAX = 4;

  typedef struct { logic [BW-1:0] beat; bit last; } beat_t;
  typedef struct { logic [BW-1:0] beat; bit last; bit abort; int path; } exp_t;

  logic clk = 1'b0;
  logic rstn;
  always #5 clk = ~clk;

  fast_path_scheduler_if #(.BEAT_WIDTH(BW), .SUP_PATHS(NP)) bus ();

  fast_path_scheduler #(
    .BEAT_WIDTH(BW), .SUP_PATHS(NP), .MAX_FIELD_BEATS(MAX)
  ) dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  beat_t src_q[NP][$];
  exp_t  exp_q[$];

  // Reference state
  bit m_locked, m_out_valid, m_err_pend;
  int m_owner, m_rr, m_cnt, m_err_path;
  bit dense;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_locked = 0; m_out_valid = 0; m_err_pend = 0;
    m_owner = 0; m_rr = 0; m_cnt = 0; m_err_path = 0;
  endtask

  task automatic add_field(input int p, input int len, input bit with_last);
    beat_t b;
    for (int i = 0; i < len; i++) begin
      b.beat = {$urandom, $urandom};
      b.last = with_last && (i == len - 1);
      src_q[p].push_back(b);
    end
  endtask

  function automatic bit all_idle();
    bit r = (exp_q.size() == 0);
    for (int p = 0; p < NP; p++) if (src_q[p].size() != 0) r = 0;
    return r;
  endfunction

  // Predict what happens at the coming rising edge from the driven inputs.
  task automatic model_step();
    int sel = -1;
    logic [NP-1:0] mask = '0;
    bit fin, wd;
    exp_t e;
    if (!rstn) begin
      model_reset();
    end else begin
      if (!m_out_valid || bus.out_ready) begin
        if (m_locked) begin
          mask[m_owner] = 1'b1;
          if (bus.in_valid[m_owner]) sel = m_owner;
        end else begin
          for (int k = 0; k < NP; k++)
            if (sel < 0 && bus.in_valid[(m_rr + k) % NP]) sel = (m_rr + k) % NP;
          if (sel >= 0) mask[sel] = 1'b1;
        end
      end
    end
    chk("in_ready", bus.in_ready, mask);
    m_err_pend = 0;
    if (sel >= 0) begin
      beat_t b = src_q[sel].pop_front();
      wd  = !b.last && (m_cnt + 1 == MAX);
      fin = b.last || wd;
      e.beat = b.beat; e.last = fin; e.abort = wd; e.path = sel;
      exp_q.push_back(e);
      m_err_pend = wd;
      if (wd) m_err_path = sel;
      if (fin) begin m_locked = 0; m_cnt = 0; m_rr = (sel + 1) % NP; end
      else     begin m_locked = 1; m_owner = sel; m_cnt++; end
      m_out_valid = 1;
    end else if (rstn && bus.out_ready) begin
      m_out_valid = 0;
    end
  endtask

  // One clock: check previous-edge effects, drive new inputs, predict.
  task automatic step(input bit rv);
    @(posedge clk);
    #1;
    chk("err_valid", bus.err_valid, m_err_pend);
    if (m_err_pend) chk("err_path", bus.err_path, m_err_path);
    chk("busy", bus.busy, m_locked);
    #1;
    rstn = rv;
    bus.out_ready = dense ? 1'b1 : ($urandom_range(0, 9) < 7);
    for (int p = 0; p < NP; p++) begin
      if (src_q[p].size() != 0 && (dense || $urandom_range(0, 3) != 0)) begin
        bus.in_valid[p] = 1'b1;
        bus.in_beat[p]  = src_q[p][0].beat;
        bus.in_last[p]  = src_q[p][0].last;
      end else begin
        bus.in_valid[p] = 1'b0;
        bus.in_beat[p]  = {$urandom, $urandom};
        bus.in_last[p]  = $urandom_range(0, 1);
      end
    end
    #1;
    model_step();
  endtask

  task automatic drain(input int budget);
    int n = 0;
    while (!all_idle() && n < budget) begin step(1); n++; end
    if (!all_idle()) chk("drain_timeout", n, budget + 1);
  endtask

  // Monitor: compare each beat the decoder accepts; check hold under stall.
  initial begin
    exp_t e;
    bit held = 0;
    logic [BW-1:0] snap_beat;
    logic [1:0]    snap_path;
    forever begin
      @(negedge clk);
      if (!rstn) begin
        held = 0;
      end else begin
        if (held) begin
          chk("hold_valid", bus.out_valid, 1);
          chk("hold_beat", bus.out_beat, snap_beat);
          chk("hold_path", bus.out_path, snap_path);
        end
        if (bus.out_valid && bus.out_ready) begin
          if (exp_q.size() == 0) begin
            chk("spurious_out_valid", bus.out_valid, 0);
          end else begin
            e = exp_q.pop_front();
            chk("out_beat", bus.out_beat, e.beat);
            chk("out_last", bus.out_last, e.last);
            chk("out_abort", bus.out_abort, e.abort);
            chk("out_path", bus.out_path, e.path);
          end
        end
        held      = bus.out_valid && !bus.out_ready;
        snap_beat = bus.out_beat;
        snap_path = bus.out_path;
      end
    end
  end

  initial begin
    int n;
    rstn = 1'b0;
    bus.in_valid = '0; bus.in_beat = '0; bus.in_last = '0; bus.out_ready = 1'b0;
    dense = 1;
    model_reset();
    step(0); step(0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_last", bus.out_last, 0);
    chk("rst_out_abort", bus.out_abort, 0);
    chk("rst_out_beat", bus.out_beat, 0);
    chk("rst_out_path", bus.out_path, 0);
    chk("rst_err_path", bus.err_path, 0);

    // Alternating single-beat fields on paths 0 and 2.
    for (int i = 0; i < 4; i++) begin add_field(0, 1, 1); add_field(2, 1, 1); end
    drain(100);

    // 3-beat field on path 1 holds off path 3.
    add_field(1, 3, 1); add_field(3, 1, 1); add_field(3, 1, 1);
    drain(100);

    // Path 0 overruns the watchdog; paths 1 and 3 compete for the next turn.
    add_field(0, 5, 0); add_field(0, 1, 1);
    add_field(1, 1, 1); add_field(3, 1, 1);
    drain(100);

    // Random fields with random valid gaps and decoder backpressure.
    dense = 0;
    for (int i = 0; i < 40; i++) add_field($urandom_range(0, NP - 1), $urandom_range(1, 6), 1);
    drain(3000);

    // Reset two beats into a locked field.
    dense = 1;
    add_field(2, 4, 1); add_field(0, 1, 1);
    n = 0;
    while (!(m_locked && m_cnt == 2) && n < 50) begin step(1); n++; end
    chk("lock_wait", m_cnt, 2);
    #1;
    rstn = 1'b0;
    exp_q.delete();
    for (int p = 0; p < NP; p++) src_q[p].delete();
    model_reset();
    #1;
    chk("async_out_valid", bus.out_valid, 0);
    chk("async_out_last", bus.out_last, 0);
    chk("async_busy", bus.busy, 0);
    chk("async_in_ready", bus.in_ready, 0);
    add_field(3, 1, 1); add_field(1, 1, 1);
    step(0); step(0);
    drain(100);

    // All paths continuously valid with single-beat fields.
    for (int i = 0; i < 3; i++) for (int p = 0; p < NP; p++) add_field(p, 1, 1);
    drain(200);
    step(1); step(1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
`default_nettype wire
